// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data RAM responder for the LOAD/STORE path.
// Accepts one request at a time, waits WAIT_STATES cycles, then pulses resp_valid.
// Optional feature macro: DATA_MEM_ALIGN_CHECK_EN (flag odd byte addresses via err).
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] INIT_VALUE  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    cnt_q;
    logic          wr_q;
    logic          mis_q;
    logic [AW-1:0] idx_q;
    logic [15:0]   wdata_q;
    logic [15:0]   rdata_q;

    logic [15:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          mis_in;
    logic [AW-1:0] idx_in;
    logic          op_wr;
    logic          op_mis;
    logic [AW-1:0] op_idx;
    logic [15:0]   op_wdata;
    logic          unused_addr;

    // Memory contents at time zero; reset deliberately leaves the RAM alone.
    initial begin
        for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] = INIT_VALUE;
        end
    end

    assign idx_in      = req_addr[AW:1];
    assign unused_addr = ^req_addr;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign mis_in = req_addr[0];
`else
    assign mis_in = 1'b0;
`endif

    assign accept = (state_q == S_IDLE) && req_valid && clk_en;

    // Operation committed on the edge entering RESP: live inputs when coming
    // straight from IDLE (zero wait states), latched request otherwise.
    always_comb begin
        enter_resp = 1'b0;
        op_wr      = wr_q;
        op_mis     = mis_q;
        op_idx     = idx_q;
        op_wdata   = wdata_q;
        if (state_q == S_IDLE) begin
            op_wr      = req_write;
            op_mis     = mis_in;
            op_idx     = idx_in;
            op_wdata   = req_wdata;
            enter_resp = accept && (WAIT_STATES == 0);
        end else if (state_q == S_WAIT) begin
            enter_resp = clk_en && (cnt_q == 4'd0);
        end
    end

    // State register; reset wins over clk_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, wait counter and registered load data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (clk_en) begin
            if (accept) begin
                wr_q    <= req_write;
                mis_q   <= mis_in;
                idx_q   <= idx_in;
                wdata_q <= req_wdata;
                cnt_q   <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
            end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                rdata_q <= (op_wr || op_mis) ? 16'h0000 : mem[op_idx];
            end
        end
    end

    // RAM write on the edge entering RESP; a reset on that edge drops the store.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && op_wr && !op_mis) begin
            mem[op_idx] <= op_wdata;
        end
    end

    // Outputs decoded from state; they hold naturally while clk_en is low.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = (state_q == S_RESP) ? rdata_q : 16'h0000;
        err        = (state_q == S_RESP) && mis_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table-driven bench for data_mem_responder.
// Instance a uses defaults (WAIT_STATES=2); instance b uses WAIT_STATES=0.
module tb_data_mem_responder;

    localparam int W_A = 2;

    typedef struct {
        string       name;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          gate;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;

    logic        a_valid, a_write;
    logic [15:0] a_addr, a_wdata;
    logic        a_ready, a_resp, a_busy, a_err;
    logic [15:0] a_rdata;

    logic        b_valid, b_write;
    logic [15:0] b_addr, b_wdata;
    logic        b_ready, b_resp, b_busy, b_err;
    logic [15:0] b_rdata;

    int total = 0;
    int bad   = 0;

    vec_t vecs[13];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(W_A), .INIT_VALUE(16'h0000)) dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata),
        .req_ready(a_ready), .resp_valid(a_resp), .resp_rdata(a_rdata),
        .busy(a_busy), .err(a_err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .INIT_VALUE(16'h0000)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .resp_valid(b_resp), .resp_rdata(b_rdata),
        .busy(b_busy), .err(b_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] exp_rdata,
                                input logic exp_err, input int gate, input int hold);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.gate = gate; v.hold = hold;
        return v;
    endfunction

    // One access on instance a; called and returns just after a negedge.
    task automatic do_access(input vec_t v);
        int n;
        int busy_cnt;
        a_valid = 1'b1;
        a_write = v.wr;
        a_addr  = v.addr;
        a_wdata = v.wdata;
        chk({v.name, "_ready"}, 32'(a_ready), 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        a_write = ~v.wr;
        a_addr  = 16'hFFFE;
        a_wdata = 16'hDEAD;
        n = 1;
        busy_cnt = 0;
        while (!a_resp && n < 40) begin
            if (a_busy) busy_cnt++;
            if (v.gate > 0 && n == 1) clk_en = 1'b0;
            if (v.gate > 0 && n == 1 + v.gate) clk_en = 1'b1;
            @(negedge clk);
            n++;
        end
        if (a_busy) busy_cnt++;
        chk({v.name, "_latency"}, 32'(n), 32'(W_A + 1 + v.gate));
        chk({v.name, "_busy"}, 32'(busy_cnt), 32'(W_A + 1 + v.gate));
        chk({v.name, "_rdata"}, 32'(a_rdata), 32'(v.exp_rdata));
        chk({v.name, "_err"}, 32'(a_err), 32'(v.exp_err));
        if (v.hold > 0) begin
            clk_en = 1'b0;
            repeat (v.hold) begin
                @(negedge clk);
                chk({v.name, "_stretch_valid"}, 32'(a_resp), 32'd1);
                chk({v.name, "_stretch_rdata"}, 32'(a_rdata), 32'(v.exp_rdata));
            end
            clk_en = 1'b1;
        end
        @(negedge clk);
        chk({v.name, "_resp_clear"}, 32'(a_resp), 32'd0);
        chk({v.name, "_idle_ready"}, 32'(a_ready), 32'd1);
        chk({v.name, "_idle_rdata"}, 32'(a_rdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk("st_beef",   1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 0, 0);
        vecs[1]  = mk("ld_beef",   1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0, 0);
        vecs[2]  = mk("st_alias",  1'b1, 16'h0200, 16'hA5A5, 16'h0000, 1'b0, 0, 0);
        vecs[3]  = mk("ld_alias",  1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0, 0, 0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        vecs[4]  = mk("ld_odd",    1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b1, 0, 0);
`else
        vecs[4]  = mk("ld_odd",    1'b0, 16'h0001, 16'h0000, 16'hA5A5, 1'b0, 0, 0);
`endif
        vecs[5]  = mk("ld_init",   1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b0, 0, 0);
        vecs[6]  = mk("st_top",    1'b1, 16'h01FE, 16'h1357, 16'h0000, 1'b0, 0, 0);
        vecs[7]  = mk("ld_top",    1'b0, 16'h03FE, 16'h0000, 16'h1357, 1'b0, 0, 0);
        vecs[8]  = mk("ld_gate",   1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 4, 0);
        vecs[9]  = mk("st_hold",   1'b1, 16'h0030, 16'h7777, 16'h0000, 1'b0, 0, 2);
        vecs[10] = mk("ld_hold",   1'b0, 16'h0030, 16'h0000, 16'h7777, 1'b0, 0, 1);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        vecs[11] = mk("st_mis",    1'b1, 16'h0011, 16'hFFFF, 16'h0000, 1'b1, 0, 0);
        vecs[12] = mk("ld_after",  1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0, 0);
`else
        vecs[11] = mk("st_mis",    1'b1, 16'h0011, 16'hFFFF, 16'h0000, 1'b0, 0, 0);
        vecs[12] = mk("ld_after",  1'b0, 16'h0010, 16'h0000, 16'hFFFF, 1'b0, 0, 0);
`endif

        reset = 1'b1; clk_en = 1'b1;
        a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_a_resp",  32'(a_resp),  32'd0);
        chk("rst_a_busy",  32'(a_busy),  32'd0);
        chk("rst_a_err",   32'(a_err),   32'd0);
        chk("rst_a_rdata", 32'(a_rdata), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_b_resp",  32'(b_resp),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_access(vecs[i]);
        end

        // Reset one cycle after accepting a store: store dropped, no response.
        a_valid = 1'b1; a_write = 1'b1; a_addr = 16'h0020; a_wdata = 16'h5555;
        @(negedge clk);
        a_valid = 1'b0;
        chk("rst_mid_busy", 32'(a_busy), 32'd1);
        reset = 1'b1;
        clk_en = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(a_ready), 32'd1);
        chk("rst_mid_resp",  32'(a_resp),  32'd0);
        chk("rst_mid_busy0", 32'(a_busy),  32'd0);
        reset = 1'b0;
        clk_en = 1'b1;
        begin
            int pulses;
            pulses = 0;
            repeat (5) begin
                @(negedge clk);
                if (a_resp) pulses++;
            end
            chk("rst_mid_no_pulse", 32'(pulses), 32'd0);
        end
        do_access(mk("ld_dropped", 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 0, 0));

        // Zero-wait-state instance: requests held valid, accepted every other cycle.
        b_valid = 1'b1; b_write = 1'b1; b_addr = 16'h0004; b_wdata = 16'h1234;
        chk("b_st_ready", 32'(b_ready), 32'd1);
        @(negedge clk);
        chk("b_st_resp",  32'(b_resp),  32'd1);
        chk("b_st_busy",  32'(b_busy),  32'd1);
        chk("b_st_nrdy",  32'(b_ready), 32'd0);
        b_write = 1'b0; b_wdata = 16'h0000;
        @(negedge clk);
        chk("b_gap_resp",  32'(b_resp),  32'd0);
        chk("b_gap_ready", 32'(b_ready), 32'd1);
        @(negedge clk);
        chk("b_ld_resp",  32'(b_resp),  32'd1);
        chk("b_ld_rdata", 32'(b_rdata), 32'h1234);
        b_valid = 1'b0;
        @(negedge clk);
        chk("b_end_resp",  32'(b_resp),  32'd0);
        chk("b_end_ready", 32'(b_ready), 32'd1);
        chk("b_end_rdata", 32'(b_rdata), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
